// File: rtl/oc_line_pkg.sv
// Shared definitions for the open-collector line transmitter.
//   state_e       : transmitter FSM states
//   Y_RELEASED    : drive level that releases the wired-AND net
//   line_is_high(): read-back helper; 1, x and z all read as high
package oc_line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_LOST
  } state_e;

  // The net has a pullup, so releasing it reads back as high.
  localparam logic Y_RELEASED = 1'bz;

  // Only a hard 0 means another driver is pulling the net low; an
  // undriven (z) or unresolved (x) read-back is the pulled-up level.
  function automatic logic line_is_high(input logic line_v);
    return (line_v !== 1'b0);
  endfunction

endpackage

// File: rtl/oc_bitcell_timer.sv
// Bit-cell timer: counts BITLEN clocks per cell and flags the last clock
// of each cell. Shared shape for the transmitter and a matching receiver.
// Ports:
//   clk         rising-edge clock
//   clr_i       synchronous active-high reset
//   restart_i   hold the count at 0 (used while no cell is running)
//   run_i       advance the count, wrapping after BITLEN-1
//   tick_last_o high during the last clock of a running cell
module oc_bitcell_timer #(
  parameter int BITLEN = 4
) (
  input  logic clk,
  input  logic clr_i,
  input  logic restart_i,
  input  logic run_i,
  output logic tick_last_o
);

  localparam int CNT_W = $clog2(BITLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITLEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == CNT_LAST);

  // NOTE: every combinational output gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values; the reset is synchronous, tested inside the edge.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_last_o = run_i && at_last;

endmodule

// File: rtl/oc_line_tx.sv
// Open-collector serial transmitter. Sends a start bit (low), WIDTH data
// bits MSB first and a stop bit (released), each BITLEN clocks long, on a
// pulled-up wired-AND net. The net is read back at the last clock of every
// data and stop cell; a released bit that reads low means another driver
// won arbitration, and the frame aborts with a one-cycle lost pulse.
// Ports:
//   clk   rising-edge clock
//   clr   synchronous active-high reset, priority over load
//   load  start request, accepted only when idle
//   din   word captured when a load is accepted
//   line  read-back of the wired net (1/x/z count as high)
//   y     open-collector drive: 0 pulls low, z releases; never 1
//   busy  frame in progress (registered)
//   done  one-cycle pulse after a completed frame (registered)
//   lost  one-cycle pulse on arbitration loss (registered)
module oc_line_tx
  import oc_line_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int BITLEN = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             line,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic             lost
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             drive_low_q, drive_low_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lost_q, lost_d;

  logic cell_run;
  logic tick_last;
  logic line_hi;

  assign cell_run = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_STOP);
  assign line_hi  = line_is_high(line);

  oc_bitcell_timer #(
    .BITLEN (BITLEN)
  ) u_timer (
    .clk         (clk),
    .clr_i       (clr),
    .restart_i   (!cell_run),
    .run_i       (cell_run),
    .tick_last_o (tick_last)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          word_d  = din;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick_last) begin
          state_d = ST_DATA;
          idx_d   = IDX_MSB;
        end
      end
      ST_DATA: begin
        if (tick_last) begin
          // A released bit that reads back low was overridden by another
          // driver; a driven-low bit cannot lose.
          if (word_q[idx_q] && !line_hi) begin
            state_d = ST_LOST;
          end else if (idx_q == '0) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick_last) begin
          if (!line_hi) begin
            state_d = ST_LOST;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_LOST: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so the registered copies
    // line up with the state they describe.
    busy_d      = (state_d == ST_START) || (state_d == ST_DATA) ||
                  (state_d == ST_STOP);
    lost_d      = (state_d == ST_LOST);
    drive_low_d = (state_d == ST_START) ||
                  ((state_d == ST_DATA) && !word_d[idx_d]);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lost_q      <= lost_d;
    end
  end

  // NOTE: the word and bit index are datapath only and carry no reset;
  // they are always written before use (on load / on entering DATA).
  always_ff @(posedge clk) begin
    word_q <= word_d;
    idx_q  <= idx_d;
  end

  assign y    = drive_low_q ? 1'b0 : Y_RELEASED;
  assign busy = busy_q;
  assign done = done_q;
  assign lost = lost_q;

endmodule

// File: tb/tb_oc_line_tx.sv
// Testbench for oc_line_tx: two transmitters share one pulled-up wired-AND
// net, plus a bench driver that can force the net low. A frame-level model
// predicts the net level and busy/done/lost for both instances every cycle.
module tb_oc_line_tx;

  localparam int W      = 8;
  localparam int B      = 4;
  localparam int FRAME  = (W + 2) * B;

  logic       clk = 1'b0;
  logic       clr;
  logic       ld   [2];
  logic [7:0] din  [2];
  logic       ext_low;
  logic       busy [2];
  logic       done [2];
  logic       lost [2];

  wire bus;
  pullup (bus);
  assign bus = ext_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  oc_line_tx #(.WIDTH(W), .BITLEN(B)) u_a (
    .clk (clk), .clr (clr), .load (ld[0]), .din (din[0]), .line (bus),
    .y (bus), .busy (busy[0]), .done (done[0]), .lost (lost[0])
  );

  oc_line_tx #(.WIDTH(W), .BITLEN(B)) u_b (
    .clk (clk), .clr (clr), .load (ld[1]), .din (din[1]), .line (bus),
    .y (bus), .busy (busy[1]), .done (done[1]), .lost (lost[1])
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // m_t is the cycle number inside the frame (0 = first start-bit clock).
  logic       m_act  [2];
  int         m_t    [2];
  logic [7:0] m_word [2];
  logic       m_done [2];
  logic       m_lost [2];
  logic [1:0] m_low;
  logic       m_net;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_t[i] = 0; m_word[i] = '0;
      m_done[i] = 1'b0; m_lost[i] = 1'b0;
    end
  end

  // Cell 0 is the start bit (low), cells 1..W carry data MSB first,
  // cell W+1 is the released stop bit.
  always_comb begin
    m_low = '0;
    for (int i = 0; i < 2; i++) begin
      if (m_act[i]) begin
        if (m_t[i] / B == 0) m_low[i] = 1'b1;
        else if (m_t[i] / B <= W) m_low[i] = !m_word[i][W - m_t[i] / B];
      end
    end
  end

  assign m_net = !(m_low[0] || m_low[1] || ext_low);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_act[i]  <= 1'b0;
        m_done[i] <= 1'b0;
        m_lost[i] <= 1'b0;
      end else if (m_act[i]) begin
        m_done[i] <= 1'b0;
        m_lost[i] <= 1'b0;
        if ((m_t[i] % B == B - 1) && (m_t[i] >= B) && !m_low[i] && !m_net) begin
          m_act[i]  <= 1'b0;
          m_lost[i] <= 1'b1;
        end else if (m_t[i] == FRAME - 1) begin
          m_act[i]  <= 1'b0;
          m_done[i] <= 1'b1;
        end else begin
          m_t[i] <= m_t[i] + 1;
        end
      end else if (m_lost[i]) begin
        m_lost[i] <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        if (ld[i]) begin
          m_act[i]  <= 1'b1;
          m_t[i]    <= 0;
          m_word[i] <= din[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("net_level", bus, m_net);
      check("busy_a", busy[0], m_act[0]);
      check("busy_b", busy[1], m_act[1]);
      check("done_a", done[0], m_done[0]);
      check("done_b", done[1], m_done[1]);
      check("lost_a", lost[0], m_lost[0]);
      check("lost_b", lost[1], m_lost[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] pat;
  logic [7:0] got;
  logic       done_seen;

  initial begin
    clr = 1'b1; ext_low = 1'b0;
    ld[0] = 1'b0; ld[1] = 1'b0; din[0] = '0; din[1] = '0;
    tick();
    chk_en = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("reset_busy", busy[0], 1'b0);
    check("reset_done", done[0], 1'b0);
    check("reset_lost", lost[0], 1'b0);
    check("reset_net_released", bus, 1'b1);

    // Single transmitter, 8'hA5: start 0, data 10100101, stop 1.
    pat = 10'b0101001011;
    ld[0] = 1'b1; din[0] = 8'hA5;
    tick();
    ld[0] = 1'b0;
    check("a5_busy_after_accept", busy[0], 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      check("a5_level", bus, pat[9 - k / B]);
      tick();
    end
    // 40 edges after the accepting edge: done up, busy down together.
    check("a5_done_at_40", done[0], 1'b1);
    check("a5_busy_low_at_done", busy[0], 1'b0);
    tick();
    check("a5_done_one_cycle", done[0], 1'b0);

    // Reset mid-frame at the 10th clock of the frame.
    ld[0] = 1'b1; din[0] = 8'hA5;
    tick();
    ld[0] = 1'b0;
    repeat (9) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("rst_busy", busy[0], 1'b0);
    check("rst_net_released", bus, 1'b1);
    done_seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      done_seen = done_seen | done[0];
      tick();
    end
    check("rst_no_done", done_seen, 1'b0);

    // Arbitration, 8'h80 vs 8'h7F. On a wired-AND net the low level
    // dominates: at bit 7 the 8'h80 side releases but reads low, so it
    // loses and the 8'h7F frame is what the net carries.
    ld[0] = 1'b1; din[0] = 8'h80;
    ld[1] = 1'b1; din[1] = 8'h7F;
    tick();
    ld[0] = 1'b0; ld[1] = 1'b0;
    got = '0;
    for (int k = 0; k < FRAME; k++) begin
      if (k == 2 * B) begin
        check("arb_lost_80", lost[0], 1'b1);
        check("arb_busy_80_dropped", busy[0], 1'b0);
        check("arb_7f_still_busy", busy[1], 1'b1);
      end
      if ((k % B == 2) && (k / B >= 1) && (k / B <= W)) got = {got[6:0], bus};
      tick();
    end
    check("arb_net_word", got, 8'h7F);
    check("arb_done_7f", done[1], 1'b1);
    check("arb_no_done_80", done[0], 1'b0);
    tick();

    // External low during the stop cell (clocks 37..39 of the frame).
    ld[0] = 1'b1; din[0] = 8'h3C;
    tick();
    ld[0] = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      ext_low = (k >= FRAME - 3);
      tick();
    end
    ext_low = 1'b0;
    check("stop_lost", lost[0], 1'b1);
    check("stop_no_done", done[0], 1'b0);
    tick();
    check("stop_lost_one_cycle", lost[0], 1'b0);
    check("stop_back_idle", busy[0], 1'b0);
    tick();

    // Busy/load: mid-frame load is ignored; load held through done starts
    // the next frame after one idle cycle.
    ld[0] = 1'b1; din[0] = 8'hC3;
    tick();
    ld[0] = 1'b0;
    got = '0;
    for (int k = 0; k < FRAME; k++) begin
      if (k == 10) begin ld[0] = 1'b1; din[0] = 8'h18; end
      if (k == 11) ld[0] = 1'b0;
      if (k == FRAME - 2) begin ld[0] = 1'b1; din[0] = 8'h5A; end
      if ((k % B == 2) && (k / B >= 1) && (k / B <= W)) got = {got[6:0], bus};
      tick();
    end
    check("bl_first_word", got, 8'hC3);
    check("bl_done", done[0], 1'b1);
    check("bl_gap_busy_low", busy[0], 1'b0);
    tick();
    ld[0] = 1'b0;
    check("bl_second_busy", busy[0], 1'b1);
    got = '0;
    for (int k = 0; k < FRAME; k++) begin
      if ((k % B == 2) && (k / B >= 1) && (k / B <= W)) got = {got[6:0], bus};
      tick();
    end
    check("bl_second_word", got, 8'h5A);
    check("bl_second_done", done[0], 1'b1);
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
